// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op-codes, FSM states and the
// arithmetic/logic op classifier.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUBAB = 3'b001;
  localparam logic [2:0] OP_SUBBA = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_ANDN  = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_XNOR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the three add/subtract ops that use and produce a carry.
  function automatic logic is_arith(input logic [2:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUBAB, OP_SUBBA: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice. Subtraction is done as an add with one
// operand inverted; the caller supplies the carry-in of 1 for two's complement.
module alu_slice
  import alu_pkg::*;
(
  input  logic [2:0] oper,
  input  logic       a,
  input  logic       b,
  input  logic       k,
  output logic       sum,
  output logic       k_next
);

  logic x;
  logic y;

  // Select adder inputs, then produce either a full-add or a bitwise result.
  always_comb begin
    x      = a;
    y      = b;
    sum    = 1'b0;
    k_next = 1'b0;
    case (oper)
      OP_SUBAB: y = ~b;
      OP_SUBBA: x = ~a;
      default: begin
        x = a;
        y = b;
      end
    endcase
    if (is_arith(oper)) begin
      sum    = x ^ y ^ k;
      k_next = (x & y) | (x & k) | (y & k);
    end else begin
      k_next = 1'b0;
      case (oper)
        OP_OR:   sum = a | b;
        OP_AND:  sum = a & b;
        OP_ANDN: sum = ~a & b;
        OP_XOR:  sum = a ^ b;
        OP_XNOR: sum = ~(a ^ b);
        default: sum = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit ALU. Operands are captured on start, processed LSB
// first through a single alu_slice with a registered carry, and the result
// and flags are published together with a one-cycle done pulse.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [2:0]       oper_q, oper_d;
  logic             k_q, k_d;
  logic             cmsb_q, cmsb_d;   // carry into the MSB, for overflow
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             slice_sum;
  logic             slice_k;

  alu_slice u_slice (
    .oper   (oper_q),
    .a      (a_sr_q[0]),
    .b      (b_sr_q[0]),
    .k      (k_q),
    .sum    (slice_sum),
    .k_next (slice_k)
  );

  // Next-state logic: capture, serial bit processing, then result publication.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    oper_d   = oper_q;
    k_d      = k_q;
    cmsb_d   = cmsb_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    c_out_d  = c_out_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          oper_d   = oper;
          // Logic ops ignore c_in so the carry chain stays at 0.
          k_d      = is_arith(oper) ? c_in : 1'b0;
          cmsb_d   = 1'b0;
          cnt_d    = '0;
          res_sr_d = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        res_sr_d = {slice_sum, res_sr_q[WIDTH-1:1]};
        k_d      = slice_k;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cmsb_d  = k_q;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        result_d = res_sr_q;
        c_out_d  = k_q;
        zero_d   = (res_sr_q == '0);
        ovf_d    = is_arith(oper_q) ? (cmsb_q ^ k_q) : 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      oper_q   <= 3'b000;
      k_q      <= 1'b0;
      cmsb_q   <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      oper_q   <= oper_d;
      k_q      <= k_d;
      cmsb_q   <= cmsb_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed, table-driven bench for serial_alu at WIDTH=8.
module tb_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   oper;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         zero;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [2:0] op;
    logic       cin;
    logic [7:0] res;
    logic       co;
    logic       z;
    logic       ov;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .oper   (oper),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .zero   (zero),
    .ovf    (ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation, scramble the inputs while it runs, and check
  // latency, output hold during RUN, the published values and the pulse width.
  task automatic apply(input vec_t v, input int idx);
    int         cyc;
    logic       got;
    logic [7:0] res_prev;
    @(negedge clk);
    res_prev = result;
    a     = v.va;
    b     = v.vb;
    oper  = v.op;
    c_in  = v.cin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_busy_start", idx), busy, 1'b1);
    cyc = 0;
    got = 1'b0;
    while (cyc < 30 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        a    = ~v.va;
        b    = v.vb ^ 8'h5A;
        oper = ~v.op;
        c_in = ~v.cin;
      end
      if (done) begin
        got = 1'b1;
      end else if (cyc == 4) begin
        chk($sformatf("v%0d_hold", idx), result, res_prev);
      end
    end
    if (!got) begin
      chk($sformatf("v%0d_done_timeout", idx), 1'b0, 1'b1);
    end else begin
      chk($sformatf("v%0d_latency", idx), cyc, W + 1);
      chk($sformatf("v%0d_result", idx), result, v.res);
      chk($sformatf("v%0d_c_out", idx), c_out, v.co);
      chk($sformatf("v%0d_zero", idx), zero, v.z);
      chk($sformatf("v%0d_ovf", idx), ovf, v.ov);
      @(negedge clk);
      chk($sformatf("v%0d_done_1cyc", idx), done, 1'b0);
      chk($sformatf("v%0d_busy_end", idx), busy, 1'b0);
      chk($sformatf("v%0d_result_held", idx), result, v.res);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int         ndone;
    logic [7:0] exp_a;
    vec_t       rv;

    //            a      b      op      cin   res    co    z     ov
    vecs[0]  = '{8'h0F, 8'h01, 3'b000, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h05, 8'h07, 3'b001, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h03, 8'h10, 3'b010, 1'b1, 8'h0D, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h7F, 8'h01, 3'b000, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'hAA, 8'hAA, 3'b110, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'hAA, 8'hAA, 3'b111, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hA0, 8'h05, 3'b011, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'hF0, 8'h3C, 3'b100, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'hF0, 8'h3C, 3'b101, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{8'h80, 8'h01, 3'b001, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{8'h00, 8'h00, 3'b011, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{8'h80, 8'h80, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    oper  = 3'b000;
    a     = 8'h00;
    b     = 8'h00;
    c_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_c_out", c_out, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i], i);
    end

    // start held for 20 cycles while a changes every cycle.
    @(negedge clk);
    oper  = 3'b000;
    b     = 8'h00;
    c_in  = 1'b0;
    a     = 8'h03;
    start = 1'b1;
    ndone = 0;
    for (int e = 0; e < 24; e++) begin
      @(negedge clk);
      chk($sformatf("hs_done_e%0d", e), done, ((e == 9) || (e == 19)) ? 1'b1 : 1'b0);
      if (done) begin
        ndone++;
        exp_a = (e == 9) ? 8'h03 : 8'(10 * 7 + 3);
        chk($sformatf("hs_result_e%0d", e), result, exp_a);
      end
      if (e + 1 < 20) begin
        a     = 8'((e + 1) * 7 + 3);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("hs_done_count", ndone, 2);
    chk("hs_idle_end", busy, 1'b0);

    // Reset four cycles into an operation: no done, outputs cleared.
    @(negedge clk);
    a     = 8'h12;
    b     = 8'h34;
    oper  = 3'b000;
    c_in  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_result", result, 8'h00);
    chk("mid_rst_c_out", c_out, 1'b0);
    chk("mid_rst_zero", zero, 1'b0);
    chk("mid_rst_ovf", ovf, 1'b0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);
    rv = '{8'h01, 8'h01, 3'b000, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    apply(rv, 100);

    // Reset and start together: reset wins.
    @(negedge clk);
    a     = 8'h44;
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    chk("rst_prio_busy", busy, 1'b0);
    chk("rst_prio_result", result, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
